// File: rtl/lcd_pkg.sv
// Shared definitions for the io_lcd byte sequencer: FSM encodings, io_lcd field positions,
// the HD44780 power-up command table and the opcodes that need the long execution wait.
package lcd_pkg;

   typedef logic [2:0] lcd_state_t;

   localparam lcd_state_t ST_POWERUP = 3'd0;
   localparam lcd_state_t ST_LOAD    = 3'd1;
   localparam lcd_state_t ST_SETUP   = 3'd2;
   localparam lcd_state_t ST_PULSE   = 3'd3;
   localparam lcd_state_t ST_HOLD    = 3'd4;
   localparam lcd_state_t ST_EXEC    = 3'd5;

   localparam int LCD_ON_BIT = 31;
   localparam int LCD_RS_BIT = 10;
   localparam int LCD_RW_BIT = 9;
   localparam int LCD_EN_BIT = 8;

   localparam int         REQ_W         = 9;
   localparam logic [7:0] INIT_FUNC_SET = 8'h38;
   localparam logic [7:0] INIT_DISP_ON  = 8'h0C;
   localparam logic [7:0] INIT_CLEAR    = 8'h01;
   localparam logic [7:0] INIT_ENTRY    = 8'h06;

   localparam logic [7:0] OP_CLEAR = 8'h01;
   localparam logic [7:0] OP_HOME  = 8'h02;

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return INIT_FUNC_SET;
         2'd1:    return INIT_DISP_ON;
         2'd2:    return INIT_CLEAR;
         2'd3:    return INIT_ENTRY;
         default: return INIT_FUNC_SET;
      endcase
   endfunction

   // Clear and home are the only commands that need the long execution wait.
   function automatic logic needs_long_exec(input logic rs, input logic [7:0] data);
      return !rs && ((data == OP_CLEAR) || (data == OP_HOME));
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock request FIFO with first-word-fall-through read; DEPTH must be a power of 2.
module sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] rdata
);

   localparam int             PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W:0]   wr_ptr_r;
   logic [PTR_W:0]   rd_ptr_r;

   // Storage write; the pointer MSB is a wrap flag so full and empty stay distinct.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
      end
   end

   // Read and write pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop && !empty) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                  (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
   assign rdata = mem_r[rd_ptr_r[PTR_W-1:0]];

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// Queues CPU command/data bytes and replays them onto io_lcd with HD44780 bus timing.
// Define LCD_INIT_SEQ_EN to include the power-up wait and the built-in init table.
module lcd_cmd_sequencer #(
   parameter int POWERUP_CYCLES = 750000,
   parameter int SETUP_CYCLES   = 2,
   parameter int EN_CYCLES      = 12,
   parameter int EXEC_CYCLES    = 2000,
   parameter int CLEAR_CYCLES   = 82000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rs,
   input  logic [7:0]  req_data,
   output logic        busy,
   output logic [31:0] io_lcd
);

   import lcd_pkg::*;

   localparam int CNT_MAX = max_int(max_int(POWERUP_CYCLES, CLEAR_CYCLES),
                                    max_int(max_int(EXEC_CYCLES, EN_CYCLES), SETUP_CYCLES));
   localparam int               CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef LCD_INIT_SEQ_EN
   localparam lcd_state_t       RESET_STATE = ST_POWERUP;
   localparam logic [CNT_W-1:0] RESET_CNT   = CNT_W'(POWERUP_CYCLES);
`else
   localparam lcd_state_t       RESET_STATE = ST_LOAD;
   localparam logic [CNT_W-1:0] RESET_CNT   = CNT_ONE;
`endif

   lcd_state_t       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             on_r;
   logic             rs_r;
   logic             en_r;
   logic [7:0]       data_r;
   logic             long_exec_r;

   logic             push_s;
   logic             pop_s;
   logic             load_s;
   logic             next_rs_s;
   logic [7:0]       next_data_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [REQ_W-1:0] fifo_rdata_s;

`ifdef LCD_INIT_SEQ_EN
   logic [2:0] init_idx_r;
   logic       init_done_s;

   assign init_done_s = init_idx_r[2];

   // Init-table cursor; parks at 4 once the whole table has been issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         init_idx_r <= 3'd0;
      end else if ((state_r == ST_LOAD) && !init_done_s) begin
         init_idx_r <= init_idx_r + 3'd1;
      end else begin
         init_idx_r <= init_idx_r;
      end
   end
`endif

   assign req_ready = !fifo_full_s && !rst;
   assign push_s    = req_valid && req_ready;
   assign busy      = rst || (state_r != ST_LOAD) || !fifo_empty_s;

   sync_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .wdata ({req_rs, req_data}),
      .pop   (pop_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .rdata (fifo_rdata_s)
   );

   // Byte source for the LOAD step: init table first, then the FIFO head.
   always_comb begin
      load_s      = 1'b0;
      pop_s       = 1'b0;
      next_rs_s   = 1'b0;
      next_data_s = 8'h00;
      if (state_r != ST_LOAD) begin
         load_s = 1'b0;
      end
`ifdef LCD_INIT_SEQ_EN
      else if (!init_done_s) begin
         load_s      = 1'b1;
         next_data_s = init_byte(init_idx_r[1:0]);
      end
`endif
      else if (!fifo_empty_s) begin
         load_s      = 1'b1;
         pop_s       = 1'b1;
         next_rs_s   = fifo_rdata_s[8];
         next_data_s = fifo_rdata_s[7:0];
      end else begin
         load_s = 1'b0;
      end
   end

   // Bus-cycle FSM; every timed state reloads cnt_r on entry and leaves when it reaches 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= RESET_STATE;
         cnt_r       <= RESET_CNT;
         on_r        <= 1'b0;
         rs_r        <= 1'b0;
         en_r        <= 1'b0;
         data_r      <= 8'h00;
         long_exec_r <= 1'b0;
      end else begin
         on_r <= 1'b1;
         case (state_r)
`ifdef LCD_INIT_SEQ_EN
            ST_POWERUP: begin
               if (cnt_r == CNT_ONE) state_r <= ST_LOAD;
               else                  cnt_r   <= cnt_r - CNT_ONE;
            end
`endif
            ST_LOAD: begin
               if (load_s) begin
                  rs_r        <= next_rs_s;
                  data_r      <= next_data_s;
                  long_exec_r <= needs_long_exec(next_rs_s, next_data_s);
                  state_r     <= ST_SETUP;
                  cnt_r       <= CNT_W'(SETUP_CYCLES);
               end
            end
            ST_SETUP: begin
               if (cnt_r == CNT_ONE) begin
                  state_r <= ST_PULSE;
                  cnt_r   <= CNT_W'(EN_CYCLES);
                  en_r    <= 1'b1;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_PULSE: begin
               if (cnt_r == CNT_ONE) begin
                  state_r <= ST_HOLD;
                  cnt_r   <= CNT_W'(SETUP_CYCLES);
                  en_r    <= 1'b0;
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_HOLD: begin
               if (cnt_r == CNT_ONE) begin
                  state_r <= ST_EXEC;
                  cnt_r   <= long_exec_r ? CNT_W'(CLEAR_CYCLES) : CNT_W'(EXEC_CYCLES);
               end else begin
                  cnt_r <= cnt_r - CNT_ONE;
               end
            end
            ST_EXEC: begin
               if (cnt_r == CNT_ONE) state_r <= ST_LOAD;
               else                  cnt_r   <= cnt_r - CNT_ONE;
            end
            default: begin
               state_r <= RESET_STATE;
               cnt_r   <= RESET_CNT;
               en_r    <= 1'b0;
            end
         endcase
      end
   end

   // io_lcd field packing; RW is tied low since the busy flag is never read back.
   always_comb begin
      io_lcd             = 32'h0000_0000;
      io_lcd[LCD_ON_BIT] = on_r;
      io_lcd[LCD_RS_BIT] = rs_r;
      io_lcd[LCD_RW_BIT] = 1'b0;
      io_lcd[LCD_EN_BIT] = en_r;
      io_lcd[7:0]        = data_r;
   end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Self-checking bench for lcd_cmd_sequencer: directed vectors, corner sequences and a
// random run scored against a schedule-level reference model. Honours LCD_INIT_SEQ_EN.
module tb_lcd_cmd_sequencer;

   localparam int POWERUP = 20;
   localparam int S       = 2;
   localparam int E       = 4;
   localparam int X       = 10;
   localparam int C       = 40;
   localparam int DEPTH   = 4;
   localparam int PER     = 1 + 2*S + E + X;
   localparam int PER_CLR = 1 + 2*S + E + C;
`ifdef LCD_INIT_SEQ_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_rs = 1'b0;
   logic [7:0]  req_data = 8'h00;
   logic        busy;
   logic [31:0] io_lcd;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   lcd_cmd_sequencer #(
      .POWERUP_CYCLES (POWERUP),
      .SETUP_CYCLES   (S),
      .EN_CYCLES      (E),
      .EXEC_CYCLES    (X),
      .CLEAR_CYCLES   (C),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rs    (req_rs),
      .req_data  (req_data),
      .busy      (busy),
      .io_lcd    (io_lcd)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: each loaded byte occupies the bus for a fixed schedule measured
   // from its load edge L; the next load may happen at edge L + period.
   logic [7:0] init_tab [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
   logic [8:0] m_q [$];
   int   m_n, m_free, m_load, m_init_left;
   bit   m_sync = 1'b0, m_have_load, m_on;
   logic m_rs;
   logic [7:0] m_data;

   always @(posedge clk) begin : model
      logic [8:0]  b;
      bit          do_push, do_load, exp_en, exp_busy;
      logic [31:0] exp_io;
      b = 9'h000;
      do_load = 1'b0;
      if (rst) begin
         m_sync      = 1'b1;
         m_n         = 0;
         m_q.delete();
         m_init_left = INIT_EN ? 4 : 0;
         m_free      = INIT_EN ? POWERUP + 1 : 1;
         m_have_load = 1'b0;
         m_on        = 1'b0;
         m_rs        = 1'b0;
         m_data      = 8'h00;
      end else if (m_sync) begin
         m_n++;
         do_push = req_valid && (m_q.size() < DEPTH);
         if (m_n >= m_free) begin
            if (m_init_left > 0) begin
               b = {1'b0, init_tab[4 - m_init_left]};
               m_init_left--;
               do_load = 1'b1;
            end else if (m_q.size() > 0) begin
               b = m_q.pop_front();
               do_load = 1'b1;
            end
         end
         if (do_push) m_q.push_back({req_rs, req_data});
         if (do_load) begin
            m_rs        = b[8];
            m_data      = b[7:0];
            m_load      = m_n;
            m_have_load = 1'b1;
            m_free      = m_n + ((!b[8] && (b[7:0] == 8'h01 || b[7:0] == 8'h02)) ? PER_CLR : PER);
         end
         m_on = 1'b1;
      end
      #1;
      if (m_sync) begin
         exp_en   = m_have_load && (m_n >= m_load + S) && (m_n < m_load + S + E);
         exp_io   = {m_on, 20'd0, m_rs, 1'b0, exp_en, m_data};
         exp_busy = rst || !((m_n >= m_free - 1) && (m_q.size() == 0));
         chk("model_io_lcd", io_lcd, exp_io);
         chk("model_busy", 32'(busy), 32'(exp_busy));
         chk("model_req_ready", 32'(req_ready), 32'(!rst && (m_q.size() < DEPTH)));
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic push_byte(input logic rs, input logic [7:0] d);
      int w = 0;
      req_valid = 1'b1;
      req_rs    = rs;
      req_data  = d;
      while (!req_ready && w < 400) begin
         @(negedge clk);
         w++;
      end
      chk("push_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Idle means busy low on two consecutive samples (an init LOAD only drops it for one).
   task automatic wait_idle();
      int w = 0;
      int low = 0;
      while (low < 2 && w < 3000) begin
         @(negedge clk);
         w++;
         if (!busy) low++;
         else       low = 0;
      end
      chk("wait_idle", 32'(busy), 32'd0);
   endtask

   typedef struct packed {
      logic        rs;
      logic [7:0]  data;
      logic [31:0] exp_io;
      logic [7:0]  exp_period;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int n, en_cnt, rises, w;
      bit stalled, prev_en;
      logic [7:0] burst [6];

      vecs[0] = '{1'b1, 8'h41, 32'h8000_0441, 8'd19};
      vecs[1] = '{1'b0, 8'h01, 32'h8000_0001, 8'd49};
      vecs[2] = '{1'b0, 8'h80, 32'h8000_0080, 8'd19};
      vecs[3] = '{1'b0, 8'h02, 32'h8000_0002, 8'd49};
      vecs[4] = '{1'b1, 8'h01, 32'h8000_0401, 8'd19};
      vecs[5] = '{1'b1, 8'h02, 32'h8000_0402, 8'd19};
      vecs[6] = '{1'b0, 8'h03, 32'h8000_0003, 8'd19};
      vecs[7] = '{1'b0, 8'h00, 32'h8000_0000, 8'd19};
      vecs[8] = '{1'b1, 8'hFF, 32'h8000_04FF, 8'd19};
      burst   = '{8'h48, 8'h49, 8'h21, 8'h20, 8'h3F, 8'h2E};

      // Reset values.
      repeat (3) @(negedge clk);
      chk("reset_io_lcd", io_lcd, 32'h0000_0000);
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("on_after_reset", io_lcd, 32'h8000_0000);
      @(negedge clk);

`ifndef LCD_INIT_SEQ_EN
      // No init table: a byte pushed one cycle after reset shows two edges later.
      push_byte(1'b1, 8'h41);
      chk("noinit_before_load", io_lcd, 32'h8000_0000);
      @(posedge clk); #1;
      chk("noinit_first_byte", io_lcd, 32'h8000_0441);
      @(negedge clk);
`endif

      // Back-to-back burst while the sequencer is occupied: the FIFO fills and stalls.
      stalled = 1'b0;
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1;
         req_rs    = 1'b1;
         req_data  = burst[i];
         w = 0;
         while (!req_ready && w < 400) begin
            stalled = 1'b1;
            @(negedge clk);
            w++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("burst_stalled", 32'(stalled), 32'd1);
      wait_idle();

      // Directed vectors from idle: latency, EN width and LOAD-to-LOAD period.
      for (int i = 0; i < 9; i++) begin
         push_byte(vecs[i].rs, vecs[i].data);
         @(posedge clk); #1;
         chk("vec_io_lcd", io_lcd, vecs[i].exp_io);
         n = 1;
         en_cnt = 0;
         while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (io_lcd[8]) en_cnt++;
         end
         chk("vec_period", 32'(n), 32'(vecs[i].exp_period));
         chk("vec_en_width", 32'(en_cnt), 32'(E));
         wait_idle();
      end

      // Reset during PULSE with two bytes queued: bus clears and the queue is lost.
      push_byte(1'b1, 8'h31);
      push_byte(1'b1, 8'h32);
      push_byte(1'b1, 8'h33);
      w = 0;
      while (!io_lcd[8] && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("reached_pulse", 32'(io_lcd[8]), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midreset_io_lcd", io_lcd, 32'h0000_0000);
      chk("midreset_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rises = 0;
      prev_en = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (io_lcd[8] && !prev_en) rises++;
         prev_en = io_lcd[8];
      end
      chk("after_reset_en_rises", 32'(rises), INIT_EN ? 32'd4 : 32'd0);
      @(negedge clk);

      // Random traffic with occasional resets, scored by the model.
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         rst       = ($urandom_range(0, 599) == 0);
         req_valid = ($urandom_range(0, 99) < 30);
         req_rs    = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       req_data = 8'h01;
            1:       req_data = 8'h02;
            default: req_data = 8'($urandom);
         endcase
      end
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b0;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lcd_cmd_sequencer.md
# lcd_cmd_sequencer

Byte-level controller for the character LCD driven through the memory-mapped `io_lcd` output register. CPU-side stores push command and data bytes into a small FIFO. The block runs the HD44780 power-up sequence, then issues each queued byte with correct setup, enable-pulse, hold and execution timing on the `io_lcd` bit fields. It sits between the output-peripheral store path and the `io_lcd` pins, replacing direct software bit-banging.

## Interface
- `POWERUP_CYCLES`, default 750000: wait after reset before the first byte (15 ms at 50 MHz).
- `SETUP_CYCLES`, default 2: RS/DATA setup before the EN rise, and hold after the EN fall.
- `EN_CYCLES`, default 12: EN high width.
- `EXEC_CYCLES`, default 2000: post-byte wait for ordinary commands and data.
- `CLEAR_CYCLES`, default 82000: post-byte wait for commands 0x01 (clear) and 0x02 (home).
- `FIFO_DEPTH`, default 8: request FIFO entries; must be a power of 2.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: a byte is offered.
- `req_ready` out 1: FIFO can accept; equals !full.
- `req_rs` in 1: 0 = command, 1 = data.
- `req_data` in 8: byte value.
- `busy` out 1: high while the FSM is not in LOAD or the FIFO is non-empty.
- `io_lcd` out 32: fields are [31] ON, [10] RS, [9] RW, [8] EN, [7:0] DATA; all other bits are 0.

## Operation
- A push occurs when `req_valid && req_ready` at a rising edge. The entry is {rs, data}.
- `req_ready` depends on FIFO fullness only. A simultaneous pop does not free the slot in the same cycle.
- FSM states: POWERUP → LOAD → SETUP → PULSE → HOLD → EXEC → LOAD.
- POWERUP: counts `POWERUP_CYCLES`, with ON=1 and EN=0.
- LOAD, init phase: while the init index is below 4, the byte comes from the init table with RS=0. The table is 0x38 (function set), 0x0C (display on), 0x01 (clear), 0x06 (entry mode).
- LOAD, normal phase: after init, the byte is popped from the FIFO if non-empty. Otherwise the FSM stays in LOAD.
- Every LOAD step registers RS and DATA into `io_lcd`, selects the EXEC wait length, and moves to SETUP.
- SETUP: `SETUP_CYCLES` cycles, EN=0.
- PULSE: `EN_CYCLES` cycles, EN=1.
- HOLD: `SETUP_CYCLES` cycles, EN=0. RS and DATA stay stable until the next LOAD.
- EXEC: waits `CLEAR_CYCLES` if RS=0 and DATA is 0x01 or 0x02, otherwise `EXEC_CYCLES`.
- RW is always 0; the busy flag is never read.
- Requests arriving during POWERUP or init are buffered and issued after init, in order.
- Full FIFO: further offers are stalled and never dropped or overwritten. Empty FIFO in LOAD: the FSM idles with `io_lcd` unchanged.

## Timing
- Reset values: `io_lcd`=0, `req_ready`=0 while `rst` is high, `busy`=1, FIFO empty, state POWERUP, init index 0.
- ON=1 from the first edge after `rst` deasserts.
- `rst` asserted mid-operation: at the next edge `io_lcd`=0 (EN drops immediately), the FIFO is flushed, and the init sequence reruns.
- Latency when idle in LOAD: a byte accepted at edge k appears on RS/DATA after edge k+1.
- EN rises after edge k+1+`SETUP_CYCLES` and stays high for exactly `EN_CYCLES` cycles.
- Per-byte period, LOAD to LOAD: 1 + 2·`SETUP_CYCLES` + `EN_CYCLES` + exec cycles.
- `busy` falls in the first LOAD cycle that finds the FIFO empty.
- All counters saturate-free: they reload on every state entry and count down to 1.

## Configuration
- `LCD_INIT_SEQ_EN`, defined: POWERUP and the 4-byte init table run as described above.
- `LCD_INIT_SEQ_EN`, undefined: POWERUP and the init table are compiled out, and the state after reset is LOAD. Software issues the init bytes itself. ON=1 and FIFO bytes are issued from the first cycle after reset.

## Structure
- Package `lcd_pkg`:
  - state enum;
  - `io_lcd` bit positions (`LCD_ON_BIT`=31, `LCD_RS_BIT`=10, `LCD_RW_BIT`=9, `LCD_EN_BIT`=8);
  - init table constants;
  - clear/home opcode constants.
- Sub-module `sync_fifo`: parameterised width (9) and depth. Ports: push, pop, full, empty, rdata. Read is first-word-fall-through.

## Test plan
All scenarios use POWERUP=20, SETUP=2, EN=4, EXEC=10, CLEAR=40, DEPTH=4.
1. Hold `rst` 3 cycles, then release → `io_lcd`=0 during reset, then ON=1 for 20 cycles. Bytes 0x38, 0x0C, 0x01, 0x06 follow with RS=0, each with a 4-cycle EN pulse. LOAD-to-LOAD gap is 19 cycles for each, except 49 after 0x01.
2. After init, push rs=1, data=0x41 → `io_lcd[10]`=1 and `[7:0]`=0x41 at k+1. EN is high for 4 cycles. `busy` falls 19 cycles after the LOAD.
3. During POWERUP, push 0x48, 0x49, 0x21, 0x20, 0x3F back-to-back → `req_ready` drops after 4 accepts and the 5th stalls. It is accepted once the first pop occurs after init. All 5 bytes are emitted in order.
4. Push command 0x01, then 0x80 → EXEC lasts 40 cycles after 0x01 and 10 after 0x80.
5. Assert `rst` during PULSE with 2 bytes queued → at the next edge `io_lcd`=0 and the FIFO is empty. The init sequence restarts; the queued bytes are never emitted.
6. Build without `LCD_INIT_SEQ_EN`, then push 0x41 one cycle after reset → DATA=0x41 two edges later, with no init bytes.
